// File: rtl/aurora_simplex_tx_ctrl_if.sv
// AXI-stream handshake bundle between the frame source and the simplex TX controller.
// master: source (drives valid/last, sees ready); slave: controller (drives ready).
interface aurora_simplex_tx_ctrl_if;
   logic axi_valid;
   logic axi_last;
   logic axi_ready;

   modport master (
      output axi_valid,
      output axi_last,
      input  axi_ready
   );

   modport slave (
      input  axi_valid,
      input  axi_last,
      output axi_ready
   );
endinterface

// File: rtl/aurora_simplex_tx_ctrl.sv
// Aurora simplex TX sequencing controller: init FSM, CC scheduling, block/lane select.
// Ports: clk/rst, lane config + tx_enable in, AXI handshake (axi), status flags,
//        lane_en, blk_sel, config_err, frame_cnt out.
module aurora_simplex_tx_ctrl #(
   parameter int MAX_LINKS     = 2,
   parameter int RESET_CYCLES  = 16,
   parameter int ALIGN_CYCLES  = 64,
   parameter int BOND_CYCLES   = 32,
   parameter int VERIFY_CYCLES = 64,
   parameter int CC_PERIOD     = 5000,
   parameter int CC_LEN        = 3,
   parameter int FRAME_CNT_W   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   single_lane,
   input  logic [MAX_LINKS-1:0]   lane_select,
   input  logic                   tx_enable,
   aurora_simplex_tx_ctrl_if.slave axi,
   output logic                   simplex_reset,
   output logic                   simplex_aligned,
   output logic                   simplex_bonded,
   output logic                   simplex_verified,
   output logic [MAX_LINKS-1:0]   lane_en,
   output logic [1:0]             blk_sel,
   output logic                   config_err,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   localparam logic [1:0] BLK_IDLE = 2'd0;
   localparam logic [1:0] BLK_DATA = 2'd1;
   localparam logic [1:0] BLK_CC   = 2'd2;

   localparam int M1 = (RESET_CYCLES > ALIGN_CYCLES) ? RESET_CYCLES : ALIGN_CYCLES;
   localparam int M2 = (BOND_CYCLES > VERIFY_CYCLES) ? BOND_CYCLES : VERIFY_CYCLES;
   localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
   localparam int CNT_W = $clog2(CNT_MAX + 1);
   localparam int CC_W  = $clog2(CC_PERIOD);
   localparam int CCL_W = $clog2(CC_LEN + 1);

   typedef enum logic [2:0] {
      S_RESET,
      S_ALIGN,
      S_BOND,
      S_VERIFY,
      S_READY
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic                 cfg_single_q;
   logic [MAX_LINKS-1:0] cfg_sel_q;
   logic [CC_W-1:0]      cc_cnt_q;
   logic [CCL_W-1:0]     cc_left_q;
   logic                 reset_q;
   logic                 aligned_q;
   logic                 bonded_q;
   logic                 verified_q;
   logic [FRAME_CNT_W-1:0] frame_q;

   logic cfg_ok;
   logic onehot;
   logic abort;
   logic rst_done;
   logic cc_wrap;
   logic cc_active;
   logic rdy;
   logic xfer;

   always_comb begin
      onehot = (lane_select != '0) &&
               ((lane_select & (lane_select - MAX_LINKS'(1))) == '0);
      cfg_ok = !single_lane || onehot;
      // Any change of the latched lane config while up forces a re-init.
      abort = (state_q != S_RESET) &&
              (!tx_enable ||
               (single_lane != cfg_single_q) ||
               (lane_select != cfg_sel_q));
      rst_done  = (cnt_q == CNT_W'(RESET_CYCLES - 1));
      cc_wrap   = (cc_cnt_q == CC_W'(CC_PERIOD - 1));
      cc_active = (cc_left_q != '0);
      rdy       = (state_q == S_READY) && !cc_active;
      xfer      = axi.axi_valid && rdy;

      state_d = state_q;
      unique case (state_q)
         S_RESET:
            if (rst_done && tx_enable && cfg_ok)
               state_d = S_ALIGN;
         S_ALIGN:
            if (cnt_q == CNT_W'(ALIGN_CYCLES - 1))
               state_d = cfg_single_q ? S_VERIFY : S_BOND;
         S_BOND:
            if (cnt_q == CNT_W'(BOND_CYCLES - 1))
               state_d = S_VERIFY;
         S_VERIFY:
            if (cnt_q == CNT_W'(VERIFY_CYCLES - 1))
               state_d = S_READY;
         S_READY:
            state_d = S_READY;
         default:
            state_d = S_RESET;
      endcase
      if (abort)
         state_d = S_RESET;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_RESET;
         cnt_q        <= '0;
         cfg_single_q <= 1'b0;
         cfg_sel_q    <= '0;
         cc_cnt_q     <= '0;
         cc_left_q    <= '0;
         reset_q      <= 1'b1;
         aligned_q    <= 1'b0;
         bonded_q     <= 1'b0;
         verified_q   <= 1'b0;
         frame_q      <= '0;
      end else begin
         state_q <= state_d;

         // Count saturates in S_RESET and is meaningless in S_READY.
         if (state_d != state_q)
            cnt_q <= '0;
         else if (!(state_q == S_RESET && rst_done) && state_q != S_READY)
            cnt_q <= cnt_q + CNT_W'(1);

         if (state_q == S_RESET && state_d == S_ALIGN) begin
            cfg_single_q <= single_lane;
            cfg_sel_q    <= lane_select;
         end

         reset_q    <= (state_d == S_RESET);
         aligned_q  <= (state_d != S_RESET);
         bonded_q   <= (state_d == S_BOND) || (state_d == S_VERIFY) ||
                       (state_d == S_READY);
         verified_q <= (state_d == S_VERIFY) || (state_d == S_READY);

         // Abort wins over a coincident CC wrap.
         if (abort || state_q == S_RESET) begin
            cc_cnt_q  <= '0;
            cc_left_q <= '0;
         end else begin
            cc_cnt_q <= cc_wrap ? '0 : cc_cnt_q + CC_W'(1);
            if (cc_wrap)
               cc_left_q <= CCL_W'(CC_LEN);
            else if (cc_active)
               cc_left_q <= cc_left_q - CCL_W'(1);
         end

         if (xfer && axi.axi_last)
            frame_q <= frame_q + FRAME_CNT_W'(1);
      end
   end

   always_comb begin
      axi.axi_ready    = rdy;
      simplex_reset    = reset_q;
      simplex_aligned  = aligned_q;
      simplex_bonded   = bonded_q;
      simplex_verified = verified_q;
      config_err       = !cfg_ok;
      frame_cnt        = frame_q;
      lane_en          = '0;
      if (state_q != S_RESET)
         lane_en = cfg_single_q ? cfg_sel_q : '1;
      blk_sel = BLK_IDLE;
      if (cc_active)
         blk_sel = BLK_CC;
      else if (xfer)
         blk_sel = BLK_DATA;
   end

endmodule

// File: doc/aurora_simplex_tx_ctrl.md
Name: aurora_simplex_tx_ctrl

Overview:
Sequencing controller for the Aurora simplex TX datapath.
- Steps the link through the simplex init sequence (reset, align, bond, verify, ready) and drives the simplex_* status flags carried in idle blocks.
- Schedules periodic clock-compensation (CC) insertion and gates the AXI stream with axi_ready.
- Selects the per-cycle block type for the 64b/66b encoders and the active lane mask. Sits between the AXI source and the encoder lanes, one instance per link.

Parameters:
MAX_LINKS, 2, number of physical lanes (width of lane_select/lane_en)
RESET_CYCLES, 16, minimum cycles in S_RESET
ALIGN_CYCLES, 64, cycles in S_ALIGN
BOND_CYCLES, 32, cycles in S_BOND (multi-lane only)
VERIFY_CYCLES, 64, cycles in S_VERIFY
CC_PERIOD, 5000, cycles between CC bursts; must be > CC_LEN
CC_LEN, 3, consecutive CC blocks per burst
FRAME_CNT_W, 16, width of frame counter

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
single_lane  in  1  1: one lane selected by lane_select; 0: all lanes
lane_select  in  MAX_LINKS  one-hot lane choice (single_lane=1)
tx_enable  in  1  request link bring-up; deassert to force re-init
axi_valid  in  1  AXI-stream word valid
axi_last  in  1  last word of frame
axi_ready  out  1  AXI-stream ready
simplex_reset  out  1  link in reset phase
simplex_aligned  out  1  align flag for idle blocks
simplex_bonded  out  1  bond flag for idle blocks
simplex_verified  out  1  verify flag for idle blocks
lane_en  out  MAX_LINKS  active lane mask to encoders
blk_sel  out  2  0 IDLE, 1 DATA, 2 CC, 3 reserved (never driven)
config_err  out  1  illegal lane config
frame_cnt  out  FRAME_CNT_W  completed frames, wraps

Behaviour:
- States: S_RESET, S_ALIGN, S_BOND, S_VERIFY, S_READY. state_cnt clears on every state entry and increments each cycle.
- Reset values: state=S_RESET, simplex_reset=1, aligned/bonded/verified=0, axi_ready=0, blk_sel=IDLE, frame_cnt=0, CC counters=0.
- Config validity:
  - cfg_ok = !single_lane || (lane_select is one-hot).
  - config_err = !cfg_ok, combinational from the live inputs.
- S_RESET:
  - Outputs: simplex_reset=1, other flags 0.
  - state_cnt saturates at RESET_CYCLES-1.
  - Go to S_ALIGN when state_cnt==RESET_CYCLES-1 && tx_enable && cfg_ok.
  - On that transition, latch single_lane and lane_select into cfg_q.
- S_ALIGN: aligned=1. After ALIGN_CYCLES cycles, go to S_BOND if cfg_q multi-lane, else directly to S_VERIFY.
- S_BOND: aligned=1, bonded=1. After BOND_CYCLES cycles, go to S_VERIFY.
- S_VERIFY: aligned, bonded, verified=1. After VERIFY_CYCLES cycles, go to S_READY.
- Bonded flag in single-lane mode: simplex_bonded=1 from S_VERIFY onward, even though S_BOND was skipped.
- S_READY: all three flags 1, simplex_reset=0.
- Abort: in any state other than S_RESET, !tx_enable or (single_lane,lane_select) != cfg_q returns to S_RESET on the next clock. This takes priority over all other transitions. CC counters clear and the frame is abandoned; frame_cnt is not incremented.
- Lane mask: lane_en = 0 in S_RESET; otherwise cfg_q single ? cfg_q lane_select : all ones.
- CC scheduler:
  - Active in all states except S_RESET. cc_cnt increments each cycle and wraps at CC_PERIOD-1.
  - On the wrap cycle, cc_left loads CC_LEN; it decrements while nonzero. cc_active = (cc_left != 0).
  - Result: with cycle 0 the first S_ALIGN cycle, CC occupies cycles CC_PERIOD .. CC_PERIOD+CC_LEN-1, repeating every CC_PERIOD.
  - CC bursts are not deferred for frames; they may split a frame.
- Block select, combinational from registered state:
  - axi_ready = (state==S_READY) && !cc_active.
  - blk_sel = CC if cc_active; else DATA if axi_valid&&axi_ready; else IDLE. Zero-latency: DATA appears in the transfer cycle.
  - Outside S_READY with no CC active: blk_sel=IDLE.
- frame_cnt increments by 1 on each axi_valid&&axi_ready&&axi_last and wraps at 2^FRAME_CNT_W. It is not cleared by aborts, only by rst.
- Simultaneous events:
  - CC wrap in the same cycle as an abort: abort wins.
  - S_VERIFY->S_READY transition in the same cycle a burst starts: axi_ready stays 0 until the burst ends.

Test Plan:
- Bring-up, single lane: single_lane=1, lane_select=01, tx_enable=1, defaults → simplex_reset=1 for 16 cycles; aligned=1 for 64; bonded and verified rise together; axi_ready=1 exactly 16+64+64 cycles after rst release; lane_en=01.
- Bring-up, multi-lane: single_lane=0 → S_BOND visible; bonded rises 64 cycles after aligned; verified rises 32 cycles later; lane_en=11.
- CC, with CC_PERIOD=100, CC_LEN=3 and axi_valid held 1 in S_READY → blk_sel=CC and axi_ready=0 for cycles 100-102, 200-202 after align entry; DATA on all other S_READY cycles.
- Frames: send 5 frames of 4 words with axi_last on word 4, one frame straddling a CC burst → frame_cnt=5, no word lost or duplicated across the CC gap.
- Abort: drop tx_enable mid-frame in S_READY → next cycle simplex_reset=1, axi_ready=0, lane_en=0, frame_cnt unchanged. Change lane_select 01→10 in S_VERIFY → S_RESET, then re-init with lane_en=10.
- Illegal config: single_lane=1, lane_select=11 → config_err=1, link stays in S_RESET indefinitely; setting lane_select=10 lets bring-up proceed.
